// File: rtl/baud_tick_gen_prog.sv
// rtl/baud_tick_gen_prog.sv - programmable integer+fraction baud tick generator (sample/mid/bit ticks)
// Optional fractional divisor built only when BAUD_FRAC_EN is defined.
module baud_tick_gen_prog #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OSR         = 16,
    parameter int DEFAULT_DIV = 651
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              en,
    input  logic              sync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pending,
    output logic              div_err,
    output logic              sample_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    localparam int OSR_W = $clog2(OSR);
    localparam logic [DIV_W:0]     CNT_ONE  = (DIV_W+1)'(1);
    localparam logic [OSR_W-1:0]   OSR_MID  = OSR_W'(OSR/2 - 1);
    localparam logic [OSR_W-1:0]   OSR_LAST = OSR_W'(OSR - 1);
    localparam logic [DIV_W-1:0]   DIV_MIN  = DIV_W'(2);

    logic [DIV_W:0]   cnt;
    logic [OSR_W-1:0] osr_cnt;
    logic [DIV_W-1:0] act_int;
    logic [DIV_W-1:0] pend_int;
    logic [DIV_W:0]   period;
    logic             ext;
    logic             load_ok;
    logic             apply;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] pend_frac;
    logic [FRAC_W:0]   acc_sum;

    // The carry of the phase accumulator stretches the current period by one cycle.
    assign acc_sum = {1'b0, acc} + {1'b0, act_frac};
    assign ext     = acc_sum[FRAC_W];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc       <= '0;
            act_frac  <= '0;
            pend_frac <= '0;
        end else begin
            if (sync)
                acc <= '0;
            else if (sample_tick)
                acc <= acc_sum[FRAC_W-1:0];
            if (apply)
                act_frac <= pend_frac;
            if (load_ok)
                pend_frac <= div_frac;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign ext         = 1'b0;
`endif

    assign period      = {1'b0, act_int} + {{DIV_W{1'b0}}, ext};
    assign sample_tick = en & ~sync & (cnt == period - CNT_ONE);
    assign mid_tick    = sample_tick & (osr_cnt == OSR_MID);
    assign bit_tick    = sample_tick & (osr_cnt == OSR_LAST);

    assign load_ok = div_load & (div_int >= DIV_MIN);
    // Swap divisors only at a period boundary or while the counter is frozen/restarted.
    assign apply   = div_pending & (sample_tick | ~en | sync);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt         <= '0;
            osr_cnt     <= '0;
            act_int     <= DIV_W'(DEFAULT_DIV);
            pend_int    <= '0;
            div_pending <= 1'b0;
            div_err     <= 1'b0;
        end else begin
            div_err <= div_load & ~load_ok;

            if (sync) begin
                cnt     <= '0;
                osr_cnt <= '0;
            end else if (sample_tick) begin
                cnt     <= '0;
                osr_cnt <= (osr_cnt == OSR_LAST) ? '0 : osr_cnt + OSR_W'(1);
            end else if (en) begin
                cnt <= cnt + CNT_ONE;
            end

            if (apply) begin
                act_int     <= pend_int;
                div_pending <= 1'b0;
            end
            // A load in the apply cycle becomes the next pending value.
            if (load_ok) begin
                pend_int    <= div_int;
                div_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// tb/tb_baud_tick_gen_prog.sv - self-checking bench for baud_tick_gen_prog
module tb_baud_tick_gen_prog;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;
    localparam int DEF    = 651;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              CLK;
    logic              RESET;
    logic              en;
    logic              sync;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_pending;
    logic              div_err;
    logic              sample_tick;
    logic              mid_tick;
    logic              bit_tick;

    baud_tick_gen_prog #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR), .DEFAULT_DIV(DEF)
    ) dut (
        .CLK(CLK), .RESET(RESET), .en(en), .sync(sync),
        .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
        .div_pending(div_pending), .div_err(div_err),
        .sample_tick(sample_tick), .mid_tick(mid_tick), .bit_tick(bit_tick)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc;
    int last_tick, last_mid, first_tick, first_mid, first_bit;

    // Reference: time elapsed in the current period, samples since restart,
    // fractional remainder carried between periods, and divisor bookkeeping.
    int m_elapsed, m_samples, m_rem;
    int m_act_i, m_act_f, m_pend_i, m_pend_f;
    bit m_pend_v, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int per;
        bit et, em, eb, ap;
        @(negedge CLK);
        cyc++;
        per = m_act_i + (((m_rem + m_act_f) >= (1 << FRAC_W)) ? 1 : 0);
        et  = en && !sync && (m_elapsed == per - 1);
        em  = et && ((m_samples % OSR) == OSR/2 - 1);
        eb  = et && ((m_samples % OSR) == OSR - 1);
        chk("sample_tick", sample_tick, et);
        chk("mid_tick", mid_tick, em);
        chk("bit_tick", bit_tick, eb);
        chk("div_pending", div_pending, m_pend_v);
        chk("div_err", div_err, m_err);
        if (sample_tick === 1'b1) begin
            last_tick = cyc;
            if (first_tick == 0) first_tick = cyc;
        end
        if (mid_tick === 1'b1) begin
            last_mid = cyc;
            if (first_mid == 0) first_mid = cyc;
        end
        if (bit_tick === 1'b1 && first_bit == 0) first_bit = cyc;

        ap = m_pend_v && (et || !en || sync);
        if (sync) begin
            m_elapsed = 0; m_samples = 0; m_rem = 0;
        end else if (et) begin
            m_elapsed = 0;
            m_samples++;
            m_rem = (m_rem + m_act_f) % (1 << FRAC_W);
        end else if (en) begin
            m_elapsed++;
        end
        if (ap) begin
            m_act_i = m_pend_i; m_act_f = m_pend_f; m_pend_v = 0;
        end
        if (div_load && div_int >= 2) begin
            m_pend_i = div_int;
            m_pend_f = FRAC_ON ? int'(div_frac) : 0;
            m_pend_v = 1;
        end
        m_err = div_load && (div_int < 2);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_tick(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            cycle();
            if (last_tick == cyc) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("tick_timeout", last_tick, cyc);
    endtask

    task automatic do_reset();
        RESET = 1; en = 0; sync = 0; div_load = 0;
        #2;
        chk("rst_sample", sample_tick, 0);
        chk("rst_mid", mid_tick, 0);
        chk("rst_bit", bit_tick, 0);
        chk("rst_pending", div_pending, 0);
        chk("rst_err", div_err, 0);
        @(posedge CLK);
        #1;
        RESET = 0;
        cyc = 0; last_tick = 0; last_mid = 0;
        first_tick = 0; first_mid = 0; first_bit = 0;
        m_elapsed = 0; m_samples = 0; m_rem = 0;
        m_act_i = DEF; m_act_f = 0; m_pend_i = 0; m_pend_f = 0;
        m_pend_v = 0; m_err = 0;
    endtask

    initial begin
        int t0, t1, t2, s, r, prev;
        CLK = 0; RESET = 1; en = 0; sync = 0;
        div_load = 0; div_int = '0; div_frac = '0;
        @(posedge CLK);
        #1;

        // Default divisor from reset
        do_reset();
        en = 1;
        run_n(16 * DEF);
        chk("first_sample", first_tick, DEF);
        chk("first_mid", first_mid, 8 * DEF);
        chk("first_bit", first_bit, 16 * DEF);

        // Load mid-period: old period completes, new one applies next
        do_reset();
        en = 1;
        run_until_tick(DEF + 5, t0);
        run_n(300);
        div_int = 100; div_frac = 0; div_load = 1;
        cycle();
        div_load = 0;
        chk("pending_after_load", div_pending, 1);
        run_until_tick(DEF + 5, t1);
        chk("old_period_kept", t1 - t0, DEF);
        chk("pending_cleared", div_pending, 0);
        run_until_tick(DEF + 5, t2);
        chk("new_period", t2 - t1, 100);

        // Rejected load
        do_reset();
        en = 1;
        run_n(100);
        div_int = 1; div_load = 1;
        cycle();
        div_load = 0;
        chk("err_pulse", div_err, 1);
        chk("err_no_pending", div_pending, 0);
        cycle();
        chk("err_one_cycle", div_err, 0);
        run_until_tick(DEF + 5, t0);
        chk("err_period_kept", t0, DEF);

        // Sync realignment
        do_reset();
        en = 1;
        for (int i = 0; i < 5; i++) run_until_tick(DEF + 5, t0);
        run_n(400);
        sync = 1;
        s = cyc + 1;
        cycle();
        sync = 0;
        run_until_tick(DEF + 5, t1);
        chk("sync_next_tick", t1 - s, DEF);
        run_n(s + 8 * DEF - cyc);
        chk("sync_mid_restart", last_mid, s + 8 * DEF);

        // Enable low holds the count
        do_reset();
        en = 1;
        run_n(200);
        en = 0;
        run_n(50);
        en = 1;
        r = cyc + 1;
        run_until_tick(DEF + 5, t0);
        chk("en_resume", t0 - r, 450);

`ifdef BAUD_FRAC_EN
        // Fractional divisor 10 + 8/16
        do_reset();
        en = 1;
        div_int = 10; div_frac = 8; div_load = 1;
        cycle();
        div_load = 0;
        run_until_tick(DEF + 5, t0);
        prev = t0;
        for (int i = 0; i < 32; i++) begin
            run_until_tick(20, t1);
            chk("frac_period", t1 - prev, (i % 2 == 0) ? 10 : 11);
            prev = t1;
        end
        chk("frac_total", prev - t0, 336);
`endif

        // Randomized traffic against the reference
        do_reset();
        en = 1;
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            sync     = ($urandom_range(0, 63) == 0);
            div_load = ($urandom_range(0, 29) == 0);
            div_int  = DIV_W'($urandom_range(0, 24));
            div_frac = FRAC_W'($urandom);
            cycle();
        end
        sync = 0; div_load = 0; en = 1;

        // Reset mid-period with a pending divisor
        div_int = 50; div_load = 1;
        cycle();
        div_load = 0;
        run_n(3);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
